// File: rtl/pla_sweep_sequencer.sv
// Exhaustive subcube sweep driver for a 12-input, single-output function under test.
// Enumerates the free variables in increasing binary order and reports ON-set size and first ON point.
module pla_sweep_sequencer #(
    parameter int N      = 12,
    parameter int SETTLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] free_mask,
    input  logic [N-1:0] fix_val,
    output logic [N-1:0] x,
    input  logic         y0,
    output logic         busy,
    output logic         done,
    output logic [N:0]   on_count,
    output logic [N-1:0] first_on,
    output logic         found
);

    localparam int HW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(SETTLE - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e        state_q, state_d;
    logic [N-1:0]  mask_q, mask_d;
    logic [N-1:0]  fix_q, fix_d;
    logic [N-1:0]  cnt_q, cnt_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [N-1:0]  x_q, x_d;
    logic [N:0]    onCount_q, onCount_d;
    logic [N-1:0]  firstOn_q, firstOn_d;
    logic          found_q, found_d;

    logic          sampleEdge;
    logic          lastPoint;
    logic [N-1:0]  cntNext;

    // Setting the fixed bits before the +1 makes the carry ripple across them, so only free bits count.
    assign sampleEdge = (hold_q == HOLD_LAST);
    assign lastPoint  = &(cnt_q | ~mask_q);
    assign cntNext    = ((cnt_q | ~mask_q) + N'(1)) & mask_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mask_q    <= '0;
            fix_q     <= '0;
            cnt_q     <= '0;
            hold_q    <= '0;
            x_q       <= '0;
            onCount_q <= '0;
            firstOn_q <= '0;
            found_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            fix_q     <= fix_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            x_q       <= x_d;
            onCount_q <= onCount_d;
            firstOn_q <= firstOn_d;
            found_q   <= found_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        fix_d     = fix_q;
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        x_d       = x_q;
        onCount_d = onCount_q;
        firstOn_d = firstOn_q;
        found_d   = found_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = RUN;
                    mask_d    = free_mask;
                    fix_d     = fix_val & ~free_mask;
                    cnt_d     = '0;
                    hold_d    = '0;
                    x_d       = fix_val & ~free_mask;
                    onCount_d = '0;
                    firstOn_d = '0;
                    found_d   = 1'b0;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (sampleEdge) begin
                    if (y0) begin
                        onCount_d = onCount_q + (N+1)'(1);
                        if (!found_q) begin
                            firstOn_d = x_q;
                            found_d   = 1'b1;
                        end
                    end
                    hold_d = '0;
                    // The last point stays on x through DONE so the caller can still see it.
                    if (lastPoint) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cntNext;
                        x_d   = cntNext | fix_q;
                    end
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign x        = x_q;
    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign on_count = onCount_q;
    assign first_on = firstOn_q;
    assign found    = found_q;

endmodule

// File: tb/tb_pla_sweep_sequencer.sv
// Bench for pla_sweep_sequencer: two instances (SETTLE=1 and SETTLE=3) against a point-list model,
// plus literal checks of the directed scenarios.
module tb_pla_sweep_sequencer;

    localparam int N = 12;

    logic          clk;
    logic          rst;
    logic          startV   [2];
    logic [N-1:0]  maskV    [2];
    logic [N-1:0]  fixV     [2];
    logic [N-1:0]  xV       [2];
    logic          y0V      [2];
    logic          busyV    [2];
    logic          doneV    [2];
    logic [N:0]    onV      [2];
    logic [N-1:0]  firstV   [2];
    logic          foundV   [2];
    int            stubSel  [2];

    int testsRun;
    int testsFailed;
    bit cmpOn;

    // Model: the ordered list of subcube points, a prefix count of ON points, and cycles since start.
    logic [N-1:0]  pts      [2][4096];
    int            onPre    [2][4097];
    int            nPts     [2];
    int            firstIdx [2];
    int            cyc      [2];
    bit            mIdle    [2];

    pla_sweep_sequencer #(.N(N), .SETTLE(1)) dut1 (
        .clk(clk), .rst(rst), .start(startV[0]), .free_mask(maskV[0]), .fix_val(fixV[0]),
        .x(xV[0]), .y0(y0V[0]), .busy(busyV[0]), .done(doneV[0]), .on_count(onV[0]),
        .first_on(firstV[0]), .found(foundV[0])
    );

    pla_sweep_sequencer #(.N(N), .SETTLE(3)) dut3 (
        .clk(clk), .rst(rst), .start(startV[1]), .free_mask(maskV[1]), .fix_val(fixV[1]),
        .x(xV[1]), .y0(y0V[1]), .busy(busyV[1]), .done(doneV[1]), .on_count(onV[1]),
        .first_on(firstV[1]), .found(foundV[1])
    );

    function automatic logic stub(input logic [N-1:0] v, input int sel);
        case (sel)
            0:       return v[0] & v[1];
            1:       return 1'b0;
            default: return v[10];
        endcase
    endfunction

    function automatic int settleOf(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    assign y0V[0] = stub(xV[0], stubSel[0]);
    assign y0V[1] = stub(xV[1], stubSel[1]);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic buildModel(input int i);
        logic [N-1:0] m;
        logic [N-1:0] f;
        logic [N-1:0] v;
        int n;
        m = maskV[i];
        f = fixV[i] & ~maskV[i];
        n = 0;
        onPre[i][0] = 0;
        firstIdx[i] = -1;
        for (int k = 0; k < 4096; k++) begin
            v = N'(k);
            if ((v & ~m) == f) begin
                pts[i][n] = v;
                onPre[i][n+1] = onPre[i][n] + (stub(v, stubSel[i]) ? 1 : 0);
                if (stub(v, stubSel[i]) && firstIdx[i] < 0) firstIdx[i] = n;
                n++;
            end
        end
        nPts[i] = n;
        cyc[i]  = 0;
        mIdle[i] = 1'b0;
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                mIdle[i] = 1'b1;
                cyc[i]   = 0;
                nPts[i]  = 0;
            end else if ((mIdle[i] || cyc[i] >= nPts[i] * settleOf(i)) && startV[i]) begin
                buildModel(i);
            end else if (!mIdle[i] && cyc[i] < 1000000) begin
                cyc[i] = cyc[i] + 1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmpOn) begin
            for (int i = 0; i < 2; i++) begin
                int total;
                int k;
                logic [N-1:0] ex;
                logic [N-1:0] ef;
                int eo;
                if (mIdle[i]) begin
                    checkOutput($sformatf("rst_x%0d", i), 32'(xV[i]), 0);
                    checkOutput($sformatf("rst_busy%0d", i), 32'(busyV[i]), 0);
                    checkOutput($sformatf("rst_done%0d", i), 32'(doneV[i]), 0);
                    checkOutput($sformatf("rst_on%0d", i), 32'(onV[i]), 0);
                    checkOutput($sformatf("rst_first%0d", i), 32'(firstV[i]), 0);
                    checkOutput($sformatf("rst_found%0d", i), 32'(foundV[i]), 0);
                end else begin
                    total = nPts[i] * settleOf(i);
                    k  = (cyc[i] < total) ? cyc[i] / settleOf(i) : nPts[i];
                    ex = (cyc[i] < total) ? pts[i][cyc[i] / settleOf(i)] : pts[i][nPts[i]-1];
                    eo = onPre[i][k];
                    ef = (eo > 0) ? pts[i][firstIdx[i]] : '0;
                    checkOutput($sformatf("x%0d", i), 32'(xV[i]), 32'(ex));
                    checkOutput($sformatf("busy%0d", i), 32'(busyV[i]), (cyc[i] < total) ? 1 : 0);
                    checkOutput($sformatf("done%0d", i), 32'(doneV[i]), (cyc[i] == total) ? 1 : 0);
                    checkOutput($sformatf("on%0d", i), 32'(onV[i]), 32'(eo));
                    checkOutput($sformatf("first%0d", i), 32'(firstV[i]), 32'(ef));
                    checkOutput($sformatf("found%0d", i), 32'(foundV[i]), (eo > 0) ? 1 : 0);
                end
            end
        end
    end

    // Pulses start for one cycle, then scrambles mask/fix to show they are not sampled mid-sweep.
    task automatic applyStimulus(input int i, input logic [N-1:0] m, input logic [N-1:0] f, input int sel);
        stubSel[i] = sel;
        maskV[i]   = m;
        fixV[i]    = f;
        startV[i]  = 1'b1;
        @(negedge clk);
        startV[i]  = 1'b0;
        maskV[i]   = ~m;
        fixV[i]    = ~f;
    endtask

    task automatic waitDone(input int i, input int budget, output int busyCnt);
        int n;
        busyCnt = 0;
        n = 0;
        while (!doneV[i] && n < budget) begin
            if (busyV[i]) busyCnt++;
            n++;
            @(negedge clk);
        end
        if (!doneV[i]) checkOutput("doneTimeout", 0, 1);
    endtask

    logic [N-1:0] seq3 [4];
    int busyCnt;

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        cmpOn       = 1'b0;
        rst         = 1'b1;
        for (int i = 0; i < 2; i++) begin
            startV[i]  = 1'b0;
            maskV[i]   = '0;
            fixV[i]    = '0;
            stubSel[i] = 0;
        end
        seq3[0] = 12'h005; seq3[1] = 12'h025; seq3[2] = 12'h085; seq3[3] = 12'h0A5;

        @(negedge clk);
        cmpOn = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("resetX", 32'(xV[0]), 0);
        checkOutput("resetOn", 32'(onV[0]), 0);

        // Full 4096-point sweep with y0 = x0 & x1.
        applyStimulus(0, 12'hFFF, 12'h000, 0);
        waitDone(0, 5000, busyCnt);
        checkOutput("fullBusyCycles", 32'(busyCnt), 4096);
        checkOutput("fullOnCount", 32'(onV[0]), 1024);
        checkOutput("fullFirstOn", 32'(firstV[0]), 32'h003);
        checkOutput("fullFound", 32'(foundV[0]), 1);
        @(negedge clk);
        checkOutput("fullDonePulse", 32'(doneV[0]), 0);

        // Two free bits over fixed 0xFF0: done five cycles after the start edge.
        applyStimulus(0, 12'h003, 12'hFF0, 0);
        for (int j = 0; j < 4; j++) begin
            checkOutput($sformatf("seqX%0d", j), 32'(xV[0]), 32'h0FF0 + 32'(j));
            @(negedge clk);
        end
        checkOutput("seqDone", 32'(doneV[0]), 1);
        checkOutput("seqOn", 32'(onV[0]), 1);
        checkOutput("seqFirst", 32'(firstV[0]), 32'h0FF3);

        // SETTLE=3 instance, constant-0 stub, free bits 5 and 7.
        applyStimulus(1, 12'h0A0, 12'h005, 1);
        for (int j = 0; j < 12; j++) begin
            checkOutput($sformatf("s3X%0d", j), 32'(xV[1]), 32'(seq3[j/3]));
            @(negedge clk);
        end
        checkOutput("s3Done", 32'(doneV[1]), 1);
        checkOutput("s3On", 32'(onV[1]), 0);
        checkOutput("s3Found", 32'(foundV[1]), 0);
        checkOutput("s3First", 32'(firstV[1]), 0);

        // Single point; start kept high through the busy cycle must be ignored.
        stubSel[0] = 2;
        maskV[0]   = 12'h000;
        fixV[0]    = 12'h7FF;
        startV[0]  = 1'b1;
        @(negedge clk);
        checkOutput("oneBusy", 32'(busyV[0]), 1);
        checkOutput("oneX", 32'(xV[0]), 32'h07FF);
        @(negedge clk);
        startV[0] = 1'b0;
        checkOutput("oneDone", 32'(doneV[0]), 1);
        checkOutput("oneBusyLow", 32'(busyV[0]), 0);
        checkOutput("oneOn", 32'(onV[0]), 1);
        checkOutput("oneFirst", 32'(firstV[0]), 32'h07FF);
        @(negedge clk);
        checkOutput("oneIdleDone", 32'(doneV[0]), 0);

        // Reset during the 100th cycle of a full sweep.
        applyStimulus(0, 12'hFFF, 12'h000, 0);
        for (int j = 0; j < 99; j++) @(negedge clk);
        checkOutput("midBusy", 32'(busyV[0]), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midRstBusy", 32'(busyV[0]), 0);
        checkOutput("midRstX", 32'(xV[0]), 0);
        checkOutput("midRstOn", 32'(onV[0]), 0);
        checkOutput("midRstFound", 32'(foundV[0]), 0);
        applyStimulus(0, 12'hFFF, 12'h000, 0);
        waitDone(0, 5000, busyCnt);
        checkOutput("reBusyCycles", 32'(busyCnt), 4096);
        checkOutput("reOnCount", 32'(onV[0]), 1024);
        checkOutput("reFirstOn", 32'(firstV[0]), 32'h003);

        // Restart from the DONE cycle.
        applyStimulus(0, 12'h003, 12'hFF0, 0);
        waitDone(0, 20, busyCnt);
        checkOutput("rsFirstSweepOn", 32'(onV[0]), 1);
        applyStimulus(0, 12'h00C, 12'h003, 0);
        checkOutput("rsBusy", 32'(busyV[0]), 1);
        checkOutput("rsNoDone", 32'(doneV[0]), 0);
        checkOutput("rsOnCleared", 32'(onV[0]), 0);
        checkOutput("rsX", 32'(xV[0]), 32'h003);
        waitDone(0, 20, busyCnt);
        checkOutput("rsBusyCycles", 32'(busyCnt), 4);
        checkOutput("rsOn", 32'(onV[0]), 4);
        checkOutput("rsFirst", 32'(firstV[0]), 32'h003);
        @(negedge clk);
        @(negedge clk);

        cmpOn = 1'b0;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/pla_sweep_sequencer.md
# pla_sweep_sequencer

Sequencer that drives the 12-input, single-output combinational benchmark functions (x0..x11 -> y0) through an exhaustive sweep of a selected subcube and accumulates statistics on the response. The caller picks which input variables are free and the fixed values of the others; the block enumerates every point of that subcube, samples y0 at each, and reports the ON-set size and the first ON-set point. It sits between the test/reduction controller and the function under test, and is the only driver of the function's inputs.

## Interface

- N, 12, number of function inputs (x0..x(N-1))
- SETTLE, 1, cycles each point is held before y0 is sampled (>=1)

- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request a sweep; accepted only in IDLE or DONE
- free_mask  in  N  bit i = 1: variable i is enumerated; latched on accepted start
- fix_val  in  N  values for non-free variables; free bits ignored; latched on accepted start
- x  out  N  registered input vector to the function under test (bit i -> xi)
- y0  in  1  function output, combinational from x
- busy  out  1  high while a sweep is in progress
- done  out  1  one-cycle pulse when a sweep completes
- on_count  out  N+1  number of swept points with y0 = 1
- first_on  out  N  first point (enumeration order) with y0 = 1
- found  out  1  at least one ON point seen in the current/last sweep

## Operation

- States: IDLE, RUN, DONE.
- IDLE/DONE + start: latch M = free_mask, F = fix_val & ~free_mask; cnt <= 0; on_count <= 0, found <= 0, first_on <= 0; x <= F; hold <= 0; go RUN. done deasserts.
- RUN: x = (cnt & M) | F at all times. hold counts 0..SETTLE-1; at hold = SETTLE-1 the edge samples y0:
  - y0 = 1: on_count += 1; if found = 0, first_on <= x, found <= 1.
  - last point when (cnt | ~M) is all ones: go DONE; x holds the last point.
  - otherwise cnt <= ((cnt | ~M) + 1) & M (subcube increment over free bits only, increasing binary order of free bits), hold <= 0.
- DONE: done = 1 for exactly one cycle, then IDLE. on_count, first_on, found, x hold until next accepted start or reset.
- Points per sweep = 2^popcount(M); M = 0 gives exactly one point (x = F); M = all ones gives 2^N points, on_count max 2^N (fits N+1 bits, no wrap).
- start while RUN: ignored, sweep continues unchanged. start in the DONE cycle: accepted (restart).
- free_mask/fix_val changes during RUN: no effect.

## Timing

- Reset values: x = 0, busy = 0, done = 0, on_count = 0, first_on = 0, found = 0, state IDLE, cnt = 0, hold = 0.
- rst mid-sweep: all of the above on the next edge; partial results discarded.
- start sampled at edge t -> x = first point and busy = 1 from cycle t+1.
- Each point held exactly SETTLE cycles; y0 sampled on the edge ending its last cycle.
- busy high for 2^k * SETTLE cycles (k = popcount(M)); done high in the following cycle with busy = 0; results final when done = 1.
- on_count/found/first_on update on the sample edge, visible next cycle.

## Test plan

- Stub y0 = x0 & x1, SETTLE=1, free_mask=0xFFF, fix_val=0 -> busy 4096 cycles, done pulse, on_count=1024, first_on=0x003, found=1.
- Same stub, free_mask=0x003, fix_val=0xFF0 -> x sequence 0xFF0,0xFF1,0xFF2,0xFF3; on_count=1, first_on=0xFF3; done 5 cycles after start edge.
- Stub y0 = 0, free_mask=0x0A0, fix_val=0x005, SETTLE=3 -> x visits 0x005,0x025,0x085,0x0A5, each 3 cycles; busy 12 cycles; on_count=0, found=0, first_on=0.
- free_mask=0, fix_val=0x7FF, stub y0 = x10 -> one point, busy 1 cycle, on_count=1, first_on=0x7FF; start during that busy cycle ignored.
- Assert rst at 100th cycle of a 0xFFF sweep -> next cycle all outputs 0, IDLE; new start then runs a full correct sweep.
- start asserted in the DONE cycle -> new sweep begins next cycle, on_count cleared, no extra done pulse.
